// File: rtl/sipo_deser_pkg.sv
// sipo_deser_pkg: state encodings, parity sense and counter sizing shared by the SIPO receiver
package sipo_deser_pkg;
  typedef enum logic {ST_RX = 1'b0, ST_PAR = 1'b1} state_e;
  localparam logic PAR_EVEN = 1'b0;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/sipo_deser_if.sv
// sipo_deser_if: serial input link plus parallel word handshake of the SIPO receiver
interface sipo_deser_if #(parameter int WIDTH = 4);
  logic             sin;
  logic             sin_valid;
  logic             sync;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             overrun;
  logic             parity_err;
  modport master (output sin, sin_valid, sync, dout_ready,
                  input  dout, dout_valid, busy, overrun, parity_err);
  modport slave  (input  sin, sin_valid, sync, dout_ready,
                  output dout, dout_valid, busy, overrun, parity_err);
endinterface

// File: rtl/sipo_deser_bit_cnt.sv
// sipo_bit_cnt: serial bit counter with async clear, sync restart, increment and terminal-count flag
module sipo_bit_cnt
  import sipo_deser_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = cnt_w(WIDTH)
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          sync,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          last_bit
);
  logic [CW-1:0] cnt_d, cnt_q;
  assign last_bit = cnt_q == CW'(WIDTH - 1);
  assign cnt      = cnt_q;
  // a restart that coincides with a bit counts that bit as the first of the new word
  always_comb cnt_d = sync ? CW'(inc) : inc ? (last_bit ? '0 : cnt_q + 1'b1) : cnt_q;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: MSB-first serial-to-parallel receiver with valid/ready output; PARITY_CHECK_EN adds an even-parity bit
module sipo_deser
  import sipo_deser_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic         clk,
  input logic         clr_n,
  sipo_deser_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
`ifdef PARITY_CHECK_EN
  localparam int SW = WIDTH;
`else
  localparam int SW = WIDTH - 1;
`endif
  state_e           state_d, state_q;
  logic [SW-1:0]    shreg_d, shreg_q;
  logic [WIDTH-1:0] dout_d, dout_q, word;
  logic             dout_valid_d, dout_valid_q;
  logic             overrun_d, overrun_q;
  logic             commit, ovr, inc, last_bit;
  logic [CW-1:0]    cnt;
  sipo_bit_cnt #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
    .clk      (clk),
    .clr_n    (clr_n),
    .sync     (bus.sync),
    .inc      (inc),
    .cnt      (cnt),
    .last_bit (last_bit)
  );
  assign inc = bus.sin_valid & (bus.sync | (state_q == ST_RX));
`ifdef PARITY_CHECK_EN
  logic par_bad, parity_err_q;
  assign word    = shreg_q;
  assign commit  = bus.sin_valid & ~bus.sync & (state_q == ST_PAR);
  assign par_bad = (^{shreg_q, bus.sin}) != PAR_EVEN;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) parity_err_q <= 1'b0;
    else        parity_err_q <= commit & par_bad;
  assign bus.parity_err = parity_err_q;
`else
  // the last bit goes straight into dout, so the shift register only needs WIDTH-1 bits
  assign word    = {shreg_q, bus.sin};
  assign commit  = bus.sin_valid & ~bus.sync & (state_q == ST_RX) & last_bit;
  assign bus.parity_err = 1'b0;
`endif
  always_comb begin
    state_d = bus.sync ? ST_RX : state_q;
`ifdef PARITY_CHECK_EN
    if (!bus.sync && bus.sin_valid) state_d = (state_q == ST_RX && last_bit) ? ST_PAR : ST_RX;
`endif
    shreg_d      = bus.sync ? SW'(inc & bus.sin) : inc ? SW'({shreg_q, bus.sin}) : shreg_q;
    ovr          = commit & dout_valid_q & ~bus.dout_ready;
    dout_d       = (commit & ~ovr) ? word : dout_q;
    dout_valid_d = commit | (dout_valid_q & ~bus.dout_ready);
    overrun_d    = ovr;
  end
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      state_q      <= ST_RX;
      shreg_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (cnt != '0) | (state_q == ST_PAR);
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: vector table plus directed corner sequences, words checked through a scoreboard at acceptance
module tb_sipo_deser;
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  typedef struct {
    logic [3:0] word;
    bit         gap;
    logic [3:0] exp_dout;
  } vec_t;
  vec_t vecs[5] = '{
    '{4'b0101, 1'b0, 4'b0101},
    '{4'b1010, 1'b0, 4'b1010},
    '{4'b1111, 1'b1, 4'b1111},
    '{4'b0000, 1'b0, 4'b0000},
    '{4'b1001, 1'b1, 4'b1001}
  };

  sipo_deser_if #(.WIDTH(4)) bus();
  sipo_deser #(.WIDTH(4)) dut (.clk(clk), .clr_n(clr_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // a word is consumed on the edge following a negedge where valid and ready are both high
  always @(negedge clk)
    if (clr_n && bus.dout_valid && bus.dout_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: unexpected word %b accepted", bus.dout);
      end else check("scoreboard", 32'(bus.dout), 32'(exp_q.pop_front()));
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.sin       = b;
    bus.sin_valid = 1'b1;
    tick();
    bus.sin_valid = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w, input bit gap, input bit pflip);
    for (int i = 3; i >= 0; i--) begin
      send_bit(w[i]);
      if (gap && i > 0) tick();
    end
`ifdef PARITY_CHECK_EN
    send_bit((^w) ^ pflip);
`else
    if (pflip) tick();
`endif
  endtask

  initial begin
    bus.sin = 1'b0;
    bus.sin_valid = 1'b0;
    bus.sync = 1'b0;
    bus.dout_ready = 1'b0;
    #2;
    check("rst dout", 32'(bus.dout), 0);
    check("rst dout_valid", 32'(bus.dout_valid), 0);
    check("rst busy", 32'(bus.busy), 0);
    check("rst overrun", 32'(bus.overrun), 0);
    check("rst parity_err", 32'(bus.parity_err), 0);
    #10 clr_n = 1'b1;
    tick();
    // single word held until ready
    exp_q.push_back(4'b0101);
    send_word(4'b0101, 1'b0, 1'b0);
    check("t1 dout", 32'(bus.dout), 32'h5);
    check("t1 valid", 32'(bus.dout_valid), 1);
    check("t1 busy", 32'(bus.busy), 0);
    repeat (3) tick();
    check("t1 held valid", 32'(bus.dout_valid), 1);
    check("t1 held dout", 32'(bus.dout), 32'h5);
    bus.dout_ready = 1'b1;
    tick();
    check("t1 valid cleared", 32'(bus.dout_valid), 0);
    // table of back-to-back and gapped words, consumer always ready
    foreach (vecs[k]) begin
      exp_q.push_back(vecs[k].exp_dout);
      send_word(vecs[k].word, vecs[k].gap, 1'b0);
      check("vec dout", 32'(bus.dout), 32'(vecs[k].exp_dout));
      check("vec valid", 32'(bus.dout_valid), 1);
      check("vec overrun", 32'(bus.overrun), 0);
      check("vec parity_err", 32'(bus.parity_err), 0);
      check("vec busy", 32'(bus.busy), 0);
    end
    tick();
    // overrun: second word dropped while the first is unacknowledged
    bus.dout_ready = 1'b0;
    exp_q.push_back(4'b1100);
    send_word(4'b1100, 1'b0, 1'b0);
    check("t3 first valid", 32'(bus.dout_valid), 1);
    check("t3 no early overrun", 32'(bus.overrun), 0);
    send_word(4'b0011, 1'b0, 1'b0);
    check("t3 overrun pulse", 32'(bus.overrun), 1);
    check("t3 dout kept", 32'(bus.dout), 32'hc);
    check("t3 busy idle", 32'(bus.busy), 0);
    tick();
    check("t3 overrun ends", 32'(bus.overrun), 0);
    check("t3 dout still", 32'(bus.dout), 32'hc);
    bus.dout_ready = 1'b1;
    tick();
    // sync mid-word restarts with the bit sampled on the sync edge
    send_bit(1'b1);
    send_bit(1'b1);
    check("t4 busy partial", 32'(bus.busy), 1);
    bus.sync = 1'b1;
    send_bit(1'b0);
    bus.sync = 1'b0;
    check("t4 busy after sync", 32'(bus.busy), 1);
    send_bit(1'b1);
    send_bit(1'b1);
    check("t4 busy 3 bits", 32'(bus.busy), 1);
    check("t4 no commit yet", 32'(bus.dout_valid), 0);
    exp_q.push_back(4'b0110);
    send_bit(1'b0);
`ifdef PARITY_CHECK_EN
    send_bit(1'b0);
`endif
    check("t4 dout", 32'(bus.dout), 32'h6);
    check("t4 valid", 32'(bus.dout_valid), 1);
    tick();
    // async reset mid-word, released off-edge
    send_bit(1'b1);
    send_bit(1'b0);
    check("t5 busy before rst", 32'(bus.busy), 1);
    #2 clr_n = 1'b0;
    #1;
    check("t5 rst dout", 32'(bus.dout), 0);
    check("t5 rst valid", 32'(bus.dout_valid), 0);
    check("t5 rst busy", 32'(bus.busy), 0);
    #3 clr_n = 1'b1;
    tick();
    exp_q.push_back(4'b1001);
    send_word(4'b1001, 1'b0, 1'b0);
    check("t5 dout", 32'(bus.dout), 32'h9);
    check("t5 valid", 32'(bus.dout_valid), 1);
    tick();
`ifdef PARITY_CHECK_EN
    exp_q.push_back(4'b0111);
    send_word(4'b0111, 1'b0, 1'b0);
    check("t6 good parity", 32'(bus.parity_err), 0);
    check("t6 good dout", 32'(bus.dout), 32'h7);
    exp_q.push_back(4'b0111);
    send_word(4'b0111, 1'b0, 1'b1);
    check("t6 bad parity", 32'(bus.parity_err), 1);
    check("t6 bad dout", 32'(bus.dout), 32'h7);
    check("t6 bad valid", 32'(bus.dout_valid), 1);
    tick();
    check("t6 parity pulse ends", 32'(bus.parity_err), 0);
`endif
    tick();
    check("scoreboard drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
